// File: rtl/demux_deserializer_if.sv
// Bus bundle for demux_deserializer: stream input handshake, mode/address
// control, slot outputs and group-out handshake.
interface demux_deserializer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] In;
  logic             In_valid;
  logic             In_ready;
  logic [1:0]       Mode;
  logic [1:0]       Addr;
  logic [1:0]       S;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             Out_valid;
  logic             Out_ready;

  modport master (
    output In, In_valid, Mode, Addr, Out_ready,
    input  In_ready, S, A, B, C, D, Out_valid
  );

  modport slave (
    input  In, In_valid, Mode, Addr, Out_ready,
    output In_ready, S, A, B, C, D, Out_valid
  );
endinterface

// File: rtl/demux_deserializer.sv
// Dual-lane 1-of-4 demultiplexing register bank. Reassembles a word stream
// produced by a 4:1 mux (select order 0..3 -> slots A..D) into a group
// presented with valid/ready; also supports addressed slot writes, hold
// and clear.
module demux_deserializer #(
  parameter int WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_deserializer_if.slave  bus
);
  localparam int SLOTS = 4;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'b00,
    MODE_ADDR   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  logic [SLOTS-1:0][WIDTH-1:0] slot_q, slot_n;
  logic [1:0]                  s_q, s_n, s_eff;
  logic                        ov_q, ov_n;
  logic                        in_ready, drain, accept;
  mode_e                       mode;

  assign mode = mode_e'(bus.Mode);

  // Handshake qualifiers; the clear mode neither drains nor accepts.
  always_comb begin
    in_ready = 1'b0;
    case (mode)
      MODE_STREAM: in_ready = !ov_q || bus.Out_ready;
      MODE_ADDR:   in_ready = 1'b1;
      default:     in_ready = 1'b0;
    endcase
    drain  = ov_q && bus.Out_ready && (mode != MODE_CLEAR);
    accept = bus.In_valid && in_ready;
  end

  // Next-state: drain is applied before the accept so a stream word taken
  // on the draining cycle starts the next group at slot A.
  always_comb begin
    slot_n = slot_q;
    s_n    = s_q;
    ov_n   = ov_q;
    s_eff  = drain ? 2'd0 : s_q;
    if (drain) begin
      ov_n = 1'b0;
      s_n  = 2'd0;
    end
    case (mode)
      MODE_STREAM: begin
        if (accept) begin
          slot_n[s_eff] = bus.In;
          s_n           = s_eff + 2'd1;
          if (s_eff == 2'd3) ov_n = 1'b1;
        end
      end
      MODE_ADDR: begin
        if (accept) slot_n[bus.Addr] = bus.In;
      end
      MODE_HOLD: ;
      MODE_CLEAR: begin
        slot_n = '0;
        s_n    = 2'd0;
        ov_n   = 1'b0;
      end
      default: ;
    endcase
  end

  // Slot registers, one per select position.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n) slot_q[i] <= '0;
      else        slot_q[i] <= slot_n[i];
    end
  end

  // Slot pointer and group-valid registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q  <= 2'd0;
      ov_q <= 1'b0;
    end else begin
      s_q  <= s_n;
      ov_q <= ov_n;
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.S         = s_q;
  assign bus.Out_valid = ov_q;
  assign bus.A         = slot_q[0];
  assign bus.B         = slot_q[1];
  assign bus.C         = slot_q[2];
  assign bus.D         = slot_q[3];
endmodule

// File: tb/tb_demux_deserializer.sv
// Self-checking bench for demux_deserializer. Completed groups are queued
// when their last word is driven and compared when Out_valid rises.
module tb_demux_deserializer;
  localparam int W = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] mon_exp;
  logic [4*W-1:0] mon_got;
  logic           ov_prev;

  demux_deserializer_if #(.WIDTH(W)) bus ();

  demux_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Group monitor: pop one expected group each time Out_valid rises.
  initial ov_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.Out_valid && !ov_prev) begin
      tests++;
      mon_got = {bus.A, bus.B, bus.C, bus.D};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL group_unexpected got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL group_data got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
    ov_prev = bus.Out_valid;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic stream_word(input logic [W-1:0] w);
    bus.Mode     = 2'b00;
    bus.In       = w;
    bus.In_valid = 1'b1;
    cyc();
    bus.In_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.A, bus.B, bus.C, bus.D} !== 8'h00) begin
      fails++; $display("FAIL reset_slots got=%h required=00", {bus.A, bus.B, bus.C, bus.D});
    end
    tests++;
    if (bus.S !== 2'd0) begin fails++; $display("FAIL reset_s got=%0d required=0", bus.S); end
    tests++;
    if (bus.Out_valid !== 1'b0) begin fails++; $display("FAIL reset_ov got=%b required=0", bus.Out_valid); end
    tests++;
    if (bus.In_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b required=1", bus.In_ready); end
    cyc();
  endtask

  task automatic test_stream_stall();
    bus.Out_ready = 1'b0;
    stream_word(2'd1);
    stream_word(2'd2);
    stream_word(2'd3);
    exp_q.push_back({2'd1, 2'd2, 2'd3, 2'd0});
    stream_word(2'd0);
    @(negedge clk);
    tests++;
    if (bus.Out_valid !== 1'b1) begin fails++; $display("FAIL stall_ov got=%b required=1", bus.Out_valid); end
    tests++;
    if (bus.S !== 2'd0) begin fails++; $display("FAIL stall_s got=%0d required=0", bus.S); end
    // Words offered while stalled must be refused and slots frozen.
    bus.In = 2'd3;
    bus.In_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (bus.In_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b required=0", bus.In_ready); end
      cyc();
    end
    bus.In_valid = 1'b0;
    tests++;
    if ({bus.A, bus.B, bus.C, bus.D} !== 8'b01_10_11_00) begin
      fails++; $display("FAIL stall_frozen got=%h required=%h", {bus.A, bus.B, bus.C, bus.D}, 8'b01_10_11_00);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [8];
    int           ov_cnt;
    words = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    ov_cnt = 0;
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) exp_q.push_back({2'd3, 2'd2, 2'd1, 2'd0});
      if (i == 7) exp_q.push_back({2'd1, 2'd1, 2'd2, 2'd2});
      bus.Mode = 2'b00;
      bus.In = words[i];
      bus.In_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.In_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready word=%0d got=%b required=1", i, bus.In_ready); end
      if (i > 0 && bus.Out_valid) ov_cnt++;
      cyc();
    end
    bus.In_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.A, bus.B, bus.C, bus.D} !== 8'b01_01_10_10) begin
      fails++; $display("FAIL b2b_group2 got=%h required=%h", {bus.A, bus.B, bus.C, bus.D}, 8'b01_01_10_10);
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.Out_valid) ov_cnt++;
      cyc();
      @(negedge clk);
    end
    tests++;
    if (ov_cnt != 2) begin fails++; $display("FAIL b2b_ov_cycles got=%0d required=2", ov_cnt); end
  endtask

  task automatic test_hold_addr();
    bus.Out_ready = 1'b0;
    stream_word(2'd3);
    stream_word(2'd3);
    bus.Mode = 2'b10;
    bus.In = 2'd0;
    bus.In_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.In_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready got=%b required=0", bus.In_ready); end
      cyc();
    end
    tests++;
    if (bus.S !== 2'd2 || bus.A !== 2'd3 || bus.B !== 2'd3) begin
      fails++; $display("FAIL hold_state got S=%0d A=%0d B=%0d required S=2 A=3 B=3", bus.S, bus.A, bus.B);
    end
    bus.Mode = 2'b01;
    bus.Addr = 2'd3;
    bus.In = 2'd1;
    cyc();
    bus.In_valid = 1'b0;
    tests++;
    if (bus.D !== 2'd1 || bus.S !== 2'd2) begin
      fails++; $display("FAIL addr_write got D=%0d S=%0d required D=1 S=2", bus.D, bus.S);
    end
    stream_word(2'd2);
    exp_q.push_back({2'd3, 2'd3, 2'd2, 2'd2});
    stream_word(2'd2);
    @(negedge clk);
    tests++;
    if (bus.C !== 2'd2 || bus.D !== 2'd2 || bus.Out_valid !== 1'b1 || bus.S !== 2'd0) begin
      fails++; $display("FAIL resume got C=%0d D=%0d ov=%b S=%0d required C=2 D=2 ov=1 S=0",
                        bus.C, bus.D, bus.Out_valid, bus.S);
    end
  endtask

  task automatic test_clear();
    bus.Out_ready = 1'b0;
    bus.Mode = 2'b11;
    bus.In = 2'd3;
    bus.In_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.In_ready !== 1'b0) begin fails++; $display("FAIL clear_in_ready got=%b required=0", bus.In_ready); end
    cyc();
    bus.In_valid = 1'b0;
    bus.Mode = 2'b00;
    tests++;
    if ({bus.A, bus.B, bus.C, bus.D} !== 8'h00 || bus.S !== 2'd0 || bus.Out_valid !== 1'b0) begin
      fails++; $display("FAIL clear_state got slots=%h S=%0d ov=%b required slots=00 S=0 ov=0",
                        {bus.A, bus.B, bus.C, bus.D}, bus.S, bus.Out_valid);
    end
  endtask

  task automatic test_reset_mid_group();
    bus.Out_ready = 1'b0;
    stream_word(2'd1);
    stream_word(2'd2);
    stream_word(2'd3);
    tests++;
    if (bus.S !== 2'd3) begin fails++; $display("FAIL mid_s got=%0d required=3", bus.S); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    tests++;
    if ({bus.A, bus.B, bus.C, bus.D} !== 8'h00 || bus.S !== 2'd0 || bus.Out_valid !== 1'b0) begin
      fails++; $display("FAIL mid_reset got slots=%h S=%0d ov=%b required slots=00 S=0 ov=0",
                        {bus.A, bus.B, bus.C, bus.D}, bus.S, bus.Out_valid);
    end
    stream_word(2'd2);
    stream_word(2'd1);
    stream_word(2'd3);
    exp_q.push_back({2'd2, 2'd1, 2'd3, 2'd1});
    stream_word(2'd1);
    tests++;
    if (bus.Out_valid !== 1'b1) begin fails++; $display("FAIL mid_fresh_ov got=%b required=1", bus.Out_valid); end
  endtask

  // A 2-bit select counter drives a 4:1 mux over two source patterns.
  task automatic test_round_trip();
    logic [4*W-1:0] src [2];
    logic [1:0]     sel;
    logic [4*W-1:0] pat;
    src[0] = {2'd1, 2'd2, 2'd3, 2'd0};
    src[1] = {2'd2, 2'd0, 2'd1, 2'd3};
    sel = 2'd0;
    bus.Out_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      pat = src[g];
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back(pat);
        bus.Mode = 2'b00;
        bus.In = pat[(3-sel)*W +: W];
        bus.In_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.S !== sel) begin fails++; $display("FAIL rt_select got=%0d required=%0d", bus.S, sel); end
        cyc();
        sel = sel + 2'd1;
      end
    end
    bus.In_valid = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.In = '0;
    bus.In_valid = 1'b0;
    bus.Mode = 2'b00;
    bus.Addr = 2'd0;
    bus.Out_ready = 1'b0;
    test_reset();
    test_stream_stall();
    test_back_to_back();
    test_hold_addr();
    test_clear();
    test_reset_mid_group();
    test_round_trip();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL groups_pending got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
